// File: rtl/dn_port_arbiter.sv
// Shares the core download/NVRAM port between the HPS ioctl loader and the
// hiscore NVRAM engine, pausing the CPU around every NVRAM engine session.
module dn_port_arbiter #(
  parameter int unsigned ROM_INDEX = 0,
  parameter int unsigned NV_INDEX  = 4,
  parameter int unsigned NV_AW     = 10,
  parameter int unsigned SETTLE    = 2,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned TIMEOUT   = 1000000
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             ioctl_download,
  input  logic [7:0]       ioctl_index,
  input  logic             ioctl_wr,
  input  logic [24:0]      ioctl_addr,
  input  logic [7:0]       ioctl_dout,
  output logic             ioctl_wait,
  input  logic             nv_req,
  input  logic             nv_stb,
  input  logic             nv_we,
  input  logic [NV_AW-1:0] nv_addr,
  input  logic [7:0]       nv_wdata,
  output logic             nv_gnt,
  output logic             nv_busy,
  output logic             nv_rvalid,
  output logic [7:0]       nv_rdata,
  output logic             nv_err,
  input  logic             paused,
  output logic             pause_req,
  output logic [15:0]      dn_addr,
  output logic [7:0]       dn_data,
  output logic             dn_wr,
  output logic             dn_nvram_wr,
  output logic             dn_nvram,
  input  logic [7:0]       dn_din
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PREQ, S_SETTLE, S_GNT, S_REL} state_e;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        wr;
    logic        nvwr;
    logic        ldnv;   // NVRAM-image download in progress
  } dn_t;

  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned PW = RD_LAT + 1;
  localparam logic [7:0]    ROM_IDX  = 8'(ROM_INDEX);
  localparam logic [7:0]    NV_IDX   = 8'(NV_INDEX);
  localparam logic [19:0]   TMO_LAST = 20'(TIMEOUT - 1);
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE - 1);

  state_e          state_q, state_d;
  logic [19:0]     tmo_q, tmo_d;
  logic [SW-1:0]   set_q, set_d;
  logic [RD_LAT:0] vld_pipe_q, vld_pipe_d;
  logic [7:0]      rdata_q, rdata_d;
  dn_t             dn_q, dn_d;

  logic busy, tmo_hit, acc, rd_acc, is_rom, is_nv, rvalid;
  logic unused_addr_hi;

  assign unused_addr_hi = ^ioctl_addr[24:16];
  assign is_rom  = (ioctl_index == ROM_IDX);
  assign is_nv   = (ioctl_index == NV_IDX);
  assign busy    = |vld_pipe_q;
  assign tmo_hit = (state_q == S_PREQ) && (tmo_q == TMO_LAST);
  // Strobes are only honoured in a live, unaborted session with no read in flight.
  assign acc     = (state_q == S_GNT) && nv_req && !ioctl_download && nv_stb && !busy;
  assign rd_acc  = acc && !nv_we;
  assign rvalid  = vld_pipe_q[RD_LAT] && (state_q == S_GNT) && !ioctl_download;

  always_ff @(posedge clk_sys) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (ioctl_download) state_d = S_LOAD;
                else if (nv_req)    state_d = S_PREQ;
      S_LOAD:   if (!ioctl_download) state_d = S_IDLE;
      S_PREQ:   if (ioctl_download) state_d = S_LOAD;
                else if (!nv_req)   state_d = S_REL;
                else if (paused)    state_d = S_SETTLE;
                else if (tmo_hit)   state_d = S_REL;
      S_SETTLE: if (ioctl_download) state_d = S_LOAD;
                else if (!nv_req)   state_d = S_REL;
                else if (paused && set_q == SET_LAST) state_d = S_GNT;
      S_GNT:    if (ioctl_download)     state_d = S_LOAD;
                else if (!nv_req && !busy) state_d = S_REL;
      S_REL:    state_d = ioctl_download ? S_LOAD : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pause_req  = (state_q == S_PREQ) || (state_q == S_SETTLE) || (state_q == S_GNT);
    nv_gnt     = (state_q == S_GNT);
    nv_err     = tmo_hit && !ioctl_download && nv_req && !paused;
    ioctl_wait = ioctl_download && (state_q != S_LOAD);
  end

  always_comb begin
    tmo_d = '0;
    if (state_q == S_PREQ) tmo_d = (tmo_q == 20'hFFFFF) ? tmo_q : tmo_q + 20'd1;
    set_d = '0;
    if (state_q == S_SETTLE && paused) set_d = set_q + SW'(1);
    // Leaving GNT (release or abort) flushes any read still in the pipe.
    vld_pipe_d = (state_d == S_GNT) ? ((vld_pipe_q << 1) | PW'(rd_acc)) : '0;
    rdata_d    = rvalid ? dn_din : rdata_q;

    dn_d      = dn_q;
    dn_d.wr   = 1'b0;
    dn_d.nvwr = 1'b0;
    dn_d.ldnv = 1'b0;
    if (state_q == S_LOAD && ioctl_download) begin
      dn_d.addr = ioctl_addr[15:0];
      dn_d.data = ioctl_dout;
      dn_d.wr   = ioctl_wr && is_rom;
      dn_d.nvwr = ioctl_wr && is_nv;
      dn_d.ldnv = is_nv;
    end else if (acc) begin
      dn_d.addr = 16'(nv_addr);
      if (nv_we) begin
        dn_d.data = nv_wdata;
        dn_d.nvwr = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      tmo_q      <= '0;
      set_q      <= '0;
      vld_pipe_q <= '0;
      rdata_q    <= '0;
      dn_q       <= '0;
    end else begin
      tmo_q      <= tmo_d;
      set_q      <= set_d;
      vld_pipe_q <= vld_pipe_d;
      rdata_q    <= rdata_d;
      dn_q       <= dn_d;
    end
  end

  assign nv_busy     = busy;
  assign nv_rvalid   = rvalid;
  assign nv_rdata    = rvalid ? dn_din : rdata_q;
  assign dn_addr     = dn_q.addr;
  assign dn_data     = dn_q.data;
  assign dn_wr       = dn_q.wr;
  assign dn_nvram_wr = dn_q.nvwr;
  assign dn_nvram    = dn_q.ldnv || (state_q == S_GNT);

endmodule
